// File: rtl/branch_sequencer.sv
// Fetch/decode/execute controller for a small program counter: decodes one
// instruction per three cycles and tells the pc when and where to step.
module branch_sequencer #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 8,
  parameter int LC_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               zero_flag,
  output logic               control,
  output logic               do_branch,
  output logic [PC_W-1:0]    branch_target,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDLC = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BZ   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_DJNZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t            state;
  state_t            state_next;
  logic [2:0]        opcode;
  logic [PC_W-1:0]   operand;
  logic [LC_W-1:0]   operand_lc;
  logic [LC_W-1:0]   lc;
  logic [LC_W-1:0]   lc_dec;
  logic [PC_W-1:0]   ret_addr;
  logic              ret_valid;

  assign imem_addr  = pc;
  assign opcode     = imem_data[INSTR_W-1:PC_W];
  assign operand    = imem_data[PC_W-1:0];
  assign operand_lc = LC_W'(operand);
  assign lc_dec     = lc - 1'b1;

  assign control = (state == S_EXEC);
  assign busy    = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // All instruction side effects land on the edge that ends DECODE, so the
  // branch decision is frozen for the whole EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      do_branch     <= 1'b0;
      branch_target <= '0;
      lc            <= '0;
      ret_addr      <= '0;
      ret_valid     <= 1'b0;
      err           <= 1'b0;
    end else if (state == S_DECODE) begin
      case (opcode)
        OP_NOP: do_branch <= 1'b0;
        OP_LDLC: begin
          lc        <= operand_lc;
          do_branch <= 1'b0;
        end
        OP_JMP: begin
          do_branch     <= 1'b1;
          branch_target <= operand;
        end
        OP_BZ: begin
          do_branch     <= zero_flag;
          branch_target <= operand;
        end
        OP_CALL: begin
          ret_addr      <= pc + 1'b1;
          ret_valid     <= 1'b1;
          do_branch     <= 1'b1;
          branch_target <= operand;
        end
        OP_RET: begin
          if (ret_valid) begin
            do_branch     <= 1'b1;
            branch_target <= ret_addr;
            ret_valid     <= 1'b0;
          end else begin
            do_branch <= 1'b0;
            err       <= 1'b1;
          end
        end
        OP_DJNZ: begin
          if (lc != '0) begin
            lc            <= lc_dec;
            do_branch     <= (lc_dec != '0);
            branch_target <= operand;
          end else begin
            do_branch <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a behavioural pc and synchronous
// instruction memory close the loop around the sequencer.
module tb_branch_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] pc;
  logic [4:0] imem_addr;
  logic [7:0] imem_data;
  logic       zero_flag;
  logic       control;
  logic       do_branch;
  logic [4:0] branch_target;
  logic       busy;
  logic       halted;
  logic       err;

  logic [7:0] mem [32];
  logic [4:0] pc_init;
  int total;
  int bad;

  branch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .imem_addr(imem_addr),
    .imem_data(imem_data), .zero_flag(zero_flag), .control(control),
    .do_branch(do_branch), .branch_target(branch_target), .busy(busy),
    .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: program counter and synchronous instruction memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pc <= pc_init;
    else if (control) pc <= do_branch ? branch_target : pc + 5'd1;
  end

  always_ff @(posedge clk) imem_data <= mem[imem_addr];

  task automatic do_reset(input logic [4:0] pc0);
    pc_init   = pc0;
    start     = 1'b0;
    zero_flag = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset;
    do_reset(5'd0);
    clear_mem();
    total++;
    if ({control, do_branch, branch_target, busy, halted, err} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b db=%b tgt=%0d busy=%b halt=%b err=%b, want all 0",
               control, do_branch, branch_target, busy, halted, err);
    end
    total++;
    if (dut.lc !== 5'd0 || dut.ret_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got lc=%0d ret_valid=%b, want 0/0", dut.lc, dut.ret_valid);
    end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || control !== 1'b0) begin
      bad++;
      $display("FAIL idle_without_start: got busy=%b ctl=%b, want 0/0", busy, control);
    end
  endtask

  task automatic test_nop;
    logic [4:0] exp_addr;
    do_reset(5'd0);
    clear_mem();
    mem[4] = 8'hE0;
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      exp_addr = 5'((k - 1) / 3);
      total++;
      if (control !== ((k % 3) == 0)) begin
        bad++;
        $display("FAIL nop_control c%0d: got %b, want %b", k, control, (k % 3) == 0);
      end
      total++;
      if (busy !== 1'b1 || imem_addr !== exp_addr) begin
        bad++;
        $display("FAIL nop_busy_addr c%0d: got busy=%b addr=%0d, want 1/%0d", k, busy, imem_addr, exp_addr);
      end
      if ((k % 3) == 0) begin
        total++;
        if (do_branch !== 1'b0) begin
          bad++;
          $display("FAIL nop_do_branch c%0d: got %b, want 0", k, do_branch);
        end
      end
    end
  endtask

  task automatic test_jmp;
    do_reset(5'd0);
    clear_mem();
    mem[0] = 8'h45;
    mem[5] = 8'hE0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (control !== 1'b1 || do_branch !== 1'b1 || branch_target !== 5'd5) begin
      bad++;
      $display("FAIL jmp_exec: got ctl=%b db=%b tgt=%0d, want 1/1/5", control, do_branch, branch_target);
    end
    @(negedge clk);
    total++;
    if (imem_addr !== 5'd5 || control !== 1'b0) begin
      bad++;
      $display("FAIL jmp_fetch: got addr=%0d ctl=%b, want 5/0", imem_addr, control);
    end
    total++;
    if (do_branch !== 1'b1 || branch_target !== 5'd5) begin
      bad++;
      $display("FAIL jmp_hold: got db=%b tgt=%0d, want 1/5", do_branch, branch_target);
    end
  endtask

  task automatic test_bz;
    do_reset(5'd0);
    clear_mem();
    mem[0] = 8'h69;
    mem[1] = 8'h69;
    mem[9] = 8'hE0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    zero_flag = 1'b1;
    #1;
    total++;
    if (control !== 1'b1 || do_branch !== 1'b0) begin
      bad++;
      $display("FAIL bz_not_taken: got ctl=%b db=%b, want 1/0", control, do_branch);
    end
    @(negedge clk);
    total++;
    if (imem_addr !== 5'd1) begin
      bad++;
      $display("FAIL bz_fallthrough_addr: got %0d, want 1", imem_addr);
    end
    repeat (2) @(negedge clk);
    zero_flag = 1'b0;
    #1;
    total++;
    if (control !== 1'b1 || do_branch !== 1'b1 || branch_target !== 5'd9) begin
      bad++;
      $display("FAIL bz_taken: got ctl=%b db=%b tgt=%0d, want 1/1/9", control, do_branch, branch_target);
    end
    @(negedge clk);
    total++;
    if (imem_addr !== 5'd9) begin
      bad++;
      $display("FAIL bz_taken_addr: got %0d, want 9", imem_addr);
    end
  endtask

  task automatic test_loop;
    logic [4:0] exp_db   [5];
    logic [4:0] exp_addr [5];
    exp_db   = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0};
    exp_addr = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd3};
    do_reset(5'd0);
    clear_mem();
    mem[0] = 8'h23;
    mem[1] = 8'hC1;
    mem[2] = 8'hC1;
    mem[3] = 8'hE0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      repeat (2) @(negedge clk);
      total++;
      if (control !== 1'b1 || do_branch !== exp_db[n][0]) begin
        bad++;
        $display("FAIL loop_exec i%0d: got ctl=%b db=%b, want 1/%b", n, control, do_branch, exp_db[n][0]);
      end
      if (exp_db[n][0]) begin
        total++;
        if (branch_target !== 5'd1) begin
          bad++;
          $display("FAIL loop_target i%0d: got %0d, want 1", n, branch_target);
        end
      end
      @(negedge clk);
      total++;
      if (imem_addr !== exp_addr[n]) begin
        bad++;
        $display("FAIL loop_addr i%0d: got %0d, want %0d", n, imem_addr, exp_addr[n]);
      end
    end
    total++;
    if (dut.lc !== 5'd0) begin
      bad++;
      $display("FAIL loop_lc_final: got %0d, want 0", dut.lc);
    end
  endtask

  task automatic test_call_ret;
    do_reset(5'd31);
    clear_mem();
    mem[31] = 8'h94;
    mem[20] = 8'hA0;
    mem[0]  = 8'hA0;
    mem[1]  = 8'hE0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (control !== 1'b1 || do_branch !== 1'b1 || branch_target !== 5'd20) begin
      bad++;
      $display("FAIL call_exec: got ctl=%b db=%b tgt=%0d, want 1/1/20", control, do_branch, branch_target);
    end
    repeat (3) @(negedge clk);
    total++;
    if (control !== 1'b1 || do_branch !== 1'b1 || branch_target !== 5'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL ret_valid: got ctl=%b db=%b tgt=%0d err=%b, want 1/1/0/0",
               control, do_branch, branch_target, err);
    end
    @(negedge clk);
    total++;
    if (imem_addr !== 5'd0) begin
      bad++;
      $display("FAIL ret_addr_wrap: got %0d, want 0", imem_addr);
    end
    repeat (2) @(negedge clk);
    total++;
    if (control !== 1'b1 || do_branch !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL ret_empty: got ctl=%b db=%b err=%b, want 1/0/1", control, do_branch, err);
    end
    repeat (4) @(negedge clk);
    total++;
    if (halted !== 1'b1 || err !== 1'b1 || imem_addr !== 5'd1) begin
      bad++;
      $display("FAIL err_sticky: got halt=%b err=%b addr=%0d, want 1/1/1", halted, err, imem_addr);
    end
  endtask

  task automatic test_halt_reset;
    do_reset(5'd0);
    clear_mem();
    mem[2] = 8'hE0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      start = (k % 3 == 0);
      @(negedge clk);
      total++;
      if (halted !== 1'b1 || busy !== 1'b0 || control !== 1'b0 || imem_addr !== 5'd2) begin
        bad++;
        $display("FAIL halt_hold c%0d: got halt=%b busy=%b ctl=%b addr=%0d, want 1/0/0/2",
                 k, halted, busy, control, imem_addr);
      end
    end
    start = 1'b0;

    do_reset(5'd0);
    clear_mem();
    mem[0] = 8'h45;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (control !== 1'b1 || do_branch !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_exec: got ctl=%b db=%b, want 1/1", control, do_branch);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (control !== 1'b0 || do_branch !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got ctl=%b db=%b busy=%b, want 0/0/0", control, do_branch, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || halted !== 1'b0 || control !== 1'b0 || imem_addr !== 5'd0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b halt=%b ctl=%b addr=%0d, want 0/0/0/0",
               busy, halted, control, imem_addr);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    start     = 1'b0;
    zero_flag = 1'b0;
    pc_init   = 5'd0;
    clear_mem();
    test_reset();
    test_nop();
    test_jmp();
    test_bz();
    test_loop();
    test_call_ret();
    test_halt_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller that drives the 5-bit program counter.
- Reads the current pc and presents it as the instruction-memory address. Decodes the returned 8-bit instruction.
- Emits one step pulse per instruction, plus the branch decision and branch target the counter consumes.
- Holds a loop counter and a 1-deep return-address register for DJNZ, CALL and RET.

Parameters:
- PC_W, 5, program counter / branch target / operand width.
- INSTR_W, 8, instruction width. Must equal 3 + PC_W: opcode in [INSTR_W-1:PC_W], operand in [PC_W-1:0].
- LC_W, 5, loop counter width. LDLC zero-extends or truncates the operand to LC_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  single-cycle pulse; starts execution from IDLE.
- pc  input  PC_W  current program counter value.
- imem_addr  output  PC_W  instruction memory address; combinationally equals pc.
- imem_data  input  INSTR_W  instruction word; synchronous memory, valid the cycle after imem_addr is presented.
- zero_flag  input  1  datapath zero flag.
- control  output  1  pc step enable, one cycle per instruction.
- do_branch  output  1  when high with control, the pc loads branch_target.
- branch_target  output  PC_W  branch destination.
- busy  output  1  high in FETCH, DECODE and EXEC.
- halted  output  1  high in HALT.
- err  output  1  sticky flag: RET executed with no valid return address.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- Reset (async) forces:
  - state=IDLE
  - control=0, do_branch=0, branch_target=0
  - busy=0, halted=0, err=0
  - loop counter lc=0, ret_addr=0, ret_valid=0
- Reset mid-instruction aborts with no further outputs.
- IDLE: waits for start=1, then goes to FETCH. start is ignored in every other state.
- FETCH: one cycle, address presented. Always goes to DECODE.
- DECODE edge: imem_data and zero_flag are sampled, then:
  - do_branch, branch_target, lc, ret_addr, ret_valid and err are updated.
  - Next state is HALT for opcode HALT, else EXEC.
- EXEC: control=1 for exactly this one cycle, with do_branch and branch_target stable. Next state is FETCH.
- Timing:
  - Each non-HALT instruction takes 3 cycles.
  - The pc changes on the edge ending EXEC.
  - control is 0 outside EXEC.
- do_branch and branch_target hold their last values outside EXEC.
- Opcodes (op = operand):
  - 000 NOP: do_branch=0.
  - 001 LDLC: lc <= op; do_branch=0.
  - 010 JMP: do_branch=1, target=op.
  - 011 BZ: do_branch=zero_flag, target=op. The zero_flag sample is taken at the DECODE edge.
  - 100 CALL:
    - ret_addr <= pc+1 mod 2^PC_W, so pc=31 gives 0.
    - ret_valid <= 1; do_branch=1, target=op.
    - A CALL with ret_valid=1 overwrites ret_addr (1-deep, no error).
  - 101 RET:
    - If ret_valid=1: do_branch=1, target=ret_addr, ret_valid <= 0.
    - If ret_valid=0: do_branch=0 (acts as NOP) and err <= 1.
  - 110 DJNZ:
    - If lc != 0: lc <= lc-1, do_branch = (lc-1 != 0), target=op.
    - If lc == 0: no decrement (no underflow) and do_branch=0.
  - 111 HALT: enters HALT without asserting control, so pc stays at the HALT address.
- HALT: halted=1, busy=0, control=0. Only reset exits.
- err is cleared only by reset.
- Registered values (lc, ret_addr, ret_valid) persist across IDLE→FETCH and are not cleared by start.

Test Plan:
- Straight-line NOPs:
  - Stimulus: reset, NOPs at 0..3, start pulse.
  - Response: control high on cycles 3, 6, 9 after start, do_branch=0, imem_addr steps 0,1,2,3.
  - busy=1 from the cycle after start.
- JMP:
  - Stimulus: JMP 5 (0x45) at address 0.
  - Response: in EXEC, control=1, do_branch=1, branch_target=5. The next FETCH drives imem_addr=5.
- BZ:
  - Stimulus: BZ 9 (0x69) with zero_flag=0, then the same instruction with zero_flag=1.
  - Response: first gives do_branch=0 and pc advances by 1. Second gives do_branch=1, target=9.
  - A zero_flag change during EXEC only does not alter the decision.
- Loop:
  - Stimulus: LDLC 3 at address 0, DJNZ 1 at address 1.
  - Response: DJNZ executes 3 times, taken twice (target 1), then falls through to pc=2 with lc=0.
  - A further DJNZ at lc=0 does not branch and lc stays 0.
- CALL / RET:
  - Stimulus: CALL 20 at pc=31, then RET, then a second RET.
  - Response: CALL gives target 20. First RET gives do_branch=1, target=0. Second RET gives do_branch=0, err=1 (sticky).
- HALT and reset:
  - Stimulus: HALT at address 2, then start pulses, then async reset asserted mid-EXEC of a JMP.
  - Response: halted=1, control=0 for 10+ cycles, start pulses ignored.
  - Reset drops control and do_branch the same cycle, without waiting for a clock edge, and the block returns to IDLE.
